// File: rtl/fp_int2fp_seq.sv
// Sequential 12-bit two's-complement integer to 13-bit float (sign, 4-bit exp, 8-bit frac) converter.
// Define FP_I2F_ROUND_EN to round half up on the dropped magnitude bits instead of truncating.
module fp_int2fp_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [11:0] din,
   output logic        ready,
   output logic        done,
   output logic        sign,
   output logic [3:0]  exp,
   output logic [7:0]  frac
);

   typedef enum logic {IDLE, NORM} state_t;

   state_t      state, state_d;
   logic [11:0] mag;
   logic [3:0]  exp_r;
   logic        sgn_r;
   logic [11:0] din_abs;
   logic        load, shift, finish;
   logic [3:0]  exp_n;
   logic [7:0]  frac_n;

   // -2048 negates to itself, which reads correctly as an unsigned magnitude of 0x800
   assign din_abs = din[11] ? (~din + 12'd1) : din;
   assign ready   = (state == IDLE);

`ifdef FP_I2F_ROUND_EN
   logic [8:0] rnd_sum;

   always_comb begin
      rnd_sum = {1'b0, mag[11:4]} + {8'd0, mag[3]};
      exp_n   = exp_r;
      frac_n  = rnd_sum[7:0];
      if (rnd_sum[8]) begin
         exp_n  = exp_r + 4'd1;
         frac_n = 8'h80;
      end
   end
`else
   always_comb begin
      exp_n  = exp_r;
      frac_n = mag[11:4];
   end
`endif

   always_comb begin
      state_d = state;
      load    = 1'b0;
      shift   = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = NORM;
            end
         end
         NORM: begin
            if (mag == 12'd0 || mag[11]) begin
               finish  = 1'b1;
               state_d = IDLE;
            end else begin
               shift = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   // Results are only written on the finishing cycle, so they persist between conversions
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mag   <= 12'd0;
         exp_r <= 4'd0;
         sgn_r <= 1'b0;
         done  <= 1'b0;
         sign  <= 1'b0;
         exp   <= 4'd0;
         frac  <= 8'd0;
      end else begin
         done <= 1'b0;
         if (load) begin
            sgn_r <= din[11];
            mag   <= din_abs;
            exp_r <= 4'd12;
         end
         if (shift) begin
            mag   <= mag << 1;
            exp_r <= exp_r - 4'd1;
         end
         if (finish) begin
            done <= 1'b1;
            if (mag == 12'd0) begin
               sign <= 1'b0;
               exp  <= 4'd0;
               frac <= 8'd0;
            end else begin
               sign <= sgn_r;
               exp  <= exp_n;
               frac <= frac_n;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_int2fp_seq.sv
// Directed self-checking bench for fp_int2fp_seq; expected values are hand-computed per vector.
module tb_fp_int2fp_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [11:0] din;
   logic        ready;
   logic        done;
   logic        sign;
   logic [3:0]  exp;
   logic [7:0]  frac;

   int checks   = 0;
   int failures = 0;

   fp_int2fp_seq dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .din     (din),
      .ready   (ready),
      .done    (done),
      .sign    (sign),
      .exp     (exp),
      .frac    (frac)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Start is held across exactly one rising edge; din is scrambled afterwards to prove it is not re-sampled
   task automatic applyStimulus(input logic [11:0] value);
      @(negedge clk);
      start = 1'b1;
      din   = value;
      @(posedge clk);
      #1;
      start = 1'b0;
      din   = 12'hA5A;
   endtask

   task automatic waitDone(input string tag, input int expLat, input logic expSign,
                           input logic [3:0] expExp, input logic [7:0] expFrac,
                           input bit pokeBusy, input bit checkPulse);
      int  cnt;
      bit  readyBad;
      cnt      = 0;
      readyBad = 0;
      while (cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
         if (start) begin
            start = 1'b0;
            din   = 12'h5A5;
         end
         if (ready !== done) readyBad = 1;
         if (done === 1'b1) break;
         if (pokeBusy && cnt == 3) begin
            start = 1'b1;
            din   = 12'h000;
         end
      end
      checkOutput({tag, "_latency"}, 16'(cnt), 16'(expLat));
      checkOutput({tag, "_ready_vs_done"}, 16'(readyBad), 16'd0);
      checkOutput({tag, "_sign"}, 16'(sign), 16'(expSign));
      checkOutput({tag, "_exp"}, 16'(exp), 16'(expExp));
      checkOutput({tag, "_frac"}, 16'(frac), 16'(expFrac));
      if (checkPulse) begin
         @(posedge clk);
         #1;
         checkOutput({tag, "_done_width"}, 16'(done), 16'd0);
         checkOutput({tag, "_hold_frac"}, 16'(frac), 16'(expFrac));
      end
   endtask

   initial begin
      int sawDone;
      reset_n = 1'b0;
      start   = 1'b0;
      din     = 12'h000;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready", 16'(ready), 16'd1);
      checkOutput("rst_done", 16'(done), 16'd0);
      checkOutput("rst_result", {3'd0, sign, exp, frac}, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle_ready", 16'(ready), 16'd1);
      checkOutput("idle_done", 16'(done), 16'd0);

      $display("[TB] din=0x001 with start pokes while busy");
      applyStimulus(12'h001);
      waitDone("one", 12, 1'b0, 4'd1, 8'h80, 1'b1, 1'b1);

      $display("[TB] din=0x800");
      applyStimulus(12'h800);
      waitDone("neg2048", 1, 1'b1, 4'd12, 8'h80, 1'b0, 1'b1);

      $display("[TB] din=0x000");
      applyStimulus(12'h000);
      waitDone("zero", 1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);

      $display("[TB] din=0x7FF");
      applyStimulus(12'h7FF);
`ifdef FP_I2F_ROUND_EN
      waitDone("max", 2, 1'b0, 4'd12, 8'h80, 1'b0, 1'b1);
`else
      waitDone("max", 2, 1'b0, 4'd11, 8'hFF, 1'b0, 1'b1);
`endif

      $display("[TB] abort din=0x003 with reset");
      applyStimulus(12'h003);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("abort_busy", 16'(ready), 16'd0);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_ready", 16'(ready), 16'd1);
      checkOutput("abort_done", 16'(done), 16'd0);
      checkOutput("abort_result", {3'd0, sign, exp, frac}, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      sawDone = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) sawDone++;
      end
      checkOutput("abort_no_done", 16'(sawDone), 16'd0);
      checkOutput("abort_idle_ready", 16'(ready), 16'd1);

      $display("[TB] back-to-back -3 then 0x040");
      applyStimulus(12'hFFD);
      waitDone("b2b_first", 11, 1'b1, 4'd2, 8'hC0, 1'b0, 1'b0);
      applyStimulus(12'h040);
      waitDone("b2b_second", 6, 1'b0, 4'd7, 8'h80, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
